uc1611_rx: RTL and testbench

- Receive-side counterpart of the UC1611 LCD driver: a synthesizable responder for the 8-bit write-only bus (lcd_data/lcd_write/lcd_cd/lcd_cs).
- Decodes the command stream and tracks page/column address with auto-increment.
- Turns data bytes into framebuffer writes for an on-chip video mirror (debug/HDMI path) and for simulation checking of the panel driver.

---
 rtl/uc1611_rx.sv | 210 +++++++++++++++++++++
 tb/tb_uc1611_rx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uc1611_rx.sv
// Receive-side model of the UC1611 write bus: decodes commands, tracks the
// page/column address with auto-increment and emits framebuffer write pulses.
module uc1611_rx #(
    parameter int COL_MAX    = 159,
    parameter int PAGE_MAX   = 143,
    parameter int RST_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] lcd_data,
    input  logic       lcd_write,
    input  logic       lcd_cd,
    input  logic       lcd_cs,
    output logic       fb_we,
    output logic [7:0] fb_page,
    output logic [7:0] fb_col,
    output logic [7:0] fb_data,
    output logic       disp_en,
    output logic [2:0] map,
    output logic [7:0] gain,
    output logic       busy,
    output logic       overrun
);

    // state     | meaning
    // S_IDLE    | decoding commands and data
    // S_OPERAND | 0x81 seen, next command byte is the gain operand
    // S_BUSY    | post-0xE2 wait, strobes dropped and flagged as overrun

    localparam int               CNT_W    = $clog2(RST_CYCLES + 2);
    localparam logic [7:0]       COL_LIM  = 8'(COL_MAX);
    localparam logic [7:0]       PAGE_LIM = 8'(PAGE_MAX);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPERAND,
        S_BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       page_q, page_d;
    logic [7:0]       col_q, col_d;
    logic [2:0]       ac_q, ac_d;
    logic [2:0]       dc_q, dc_d;
    logic [2:0]       map_q, map_d;
    logic [7:0]       gain_q, gain_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic             we_q, we_d;
    logic [7:0]       fbp_q, fbp_d;
    logic [7:0]       fbc_q, fbc_d;
    logic [7:0]       fbd_q, fbd_d;

    logic             accept;
    logic             page_edge, col_edge;
    logic [7:0]       page_pri, page_sec, col_pri, col_sec;
    logic [7:0]       page_adv, col_adv;

    assign accept = lcd_write & lcd_cs;

    // Page steps in the AC[2] direction; *_edge marks running off the range,
    // which carries into the other counter when this one is primary.
    always_comb begin
        page_edge = 1'b0;
        page_pri  = page_q;
        page_sec  = page_q;
        if (!ac_q[2]) begin
            page_edge = (page_q >= PAGE_LIM);
            page_pri  = page_edge ? 8'd0 : page_q + 8'd1;
            page_sec  = page_edge ? (ac_q[0] ? 8'd0 : PAGE_LIM) : page_q + 8'd1;
        end else if (page_q == 8'd0) begin
            page_edge = 1'b1;
            page_pri  = PAGE_LIM;
            page_sec  = ac_q[0] ? PAGE_LIM : 8'd0;
        end else if (page_q > PAGE_LIM) begin
            page_edge = 1'b1;
            page_pri  = 8'd0;
            page_sec  = ac_q[0] ? 8'd0 : PAGE_LIM;
        end else begin
            page_pri  = page_q - 8'd1;
            page_sec  = page_q - 8'd1;
        end

        col_edge = (col_q >= COL_LIM);
        col_pri  = col_edge ? 8'd0 : col_q + 8'd1;
        col_sec  = col_edge ? (ac_q[0] ? 8'd0 : COL_LIM) : col_q + 8'd1;

        if (!ac_q[1]) begin
            col_adv  = col_pri;
            page_adv = col_edge ? page_sec : page_q;
        end else begin
            page_adv = page_pri;
            col_adv  = page_edge ? col_sec : col_q;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        col_d   = col_q;
        ac_d    = ac_q;
        dc_d    = dc_q;
        map_d   = map_q;
        gain_d  = gain_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        we_d    = 1'b0;
        fbp_d   = fbp_q;
        fbc_d   = fbc_q;
        fbd_d   = fbd_q;

        case (state_q)
            S_BUSY: begin
                if (accept) ovr_d = 1'b1;
                if (cnt_q <= CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                if (accept) begin
                    if (lcd_cd) begin
                        we_d    = 1'b1;
                        fbp_d   = page_q;
                        fbc_d   = col_q;
                        fbd_d   = lcd_data;
                        page_d  = page_adv;
                        col_d   = col_adv;
                        state_d = S_IDLE;
                    end else if (state_q == S_OPERAND) begin
                        gain_d  = lcd_data;
                        state_d = S_IDLE;
                    end else begin
                        casez (lcd_data)
                            8'b0000_????: col_d[3:0]  = lcd_data[3:0];
                            8'b0001_????: col_d[7:4]  = lcd_data[3:0];
                            8'b0110_????: page_d[3:0] = lcd_data[3:0];
                            8'b0111_0???: page_d[7:4] = {1'b0, lcd_data[2:0]};
                            8'b1000_1???: ac_d        = lcd_data[2:0];
                            8'b1010_1???: dc_d        = lcd_data[2:0];
                            8'b1100_0???: map_d       = lcd_data[2:0];
                            8'h81:        state_d     = S_OPERAND;
                            8'hE2: begin
                                page_d  = 8'd0;
                                col_d   = 8'd0;
                                ac_d    = 3'b001;
                                dc_d    = 3'b000;
                                map_d   = 3'b000;
                                gain_d  = 8'd0;
                                fbp_d   = 8'd0;
                                fbc_d   = 8'd0;
                                fbd_d   = 8'd0;
                                cnt_d   = CNT_LOAD;
                                state_d = S_BUSY;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            page_q  <= 8'd0;
            col_q   <= 8'd0;
            ac_q    <= 3'b001;
            dc_q    <= 3'b000;
            map_q   <= 3'b000;
            gain_q  <= 8'd0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            we_q    <= 1'b0;
            fbp_q   <= 8'd0;
            fbc_q   <= 8'd0;
            fbd_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            col_q   <= col_d;
            ac_q    <= ac_d;
            dc_q    <= dc_d;
            map_q   <= map_d;
            gain_q  <= gain_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            we_q    <= we_d;
            fbp_q   <= fbp_d;
            fbc_q   <= fbc_d;
            fbd_q   <= fbd_d;
        end
    end

    assign fb_we   = we_q;
    assign fb_page = fbp_q;
    assign fb_col  = fbc_q;
    assign fb_data = fbd_q;
    assign disp_en = &dc_q;
    assign map     = map_q;
    assign gain    = gain_q;
    assign busy    = (state_q == S_BUSY);
    assign overrun = ovr_q;

endmodule

// File: tb/tb_uc1611_rx.sv
// Bench for uc1611_rx: directed sequences with literal expectations, then
// randomized bus traffic compared every cycle against a behavioural model.
module tb_uc1611_rx;

    localparam int COL_MAX    = 159;
    localparam int PAGE_MAX   = 143;
    localparam int RST_CYCLES = 16;

    logic       clk;
    logic       reset;
    logic [7:0] lcd_data;
    logic       lcd_write;
    logic       lcd_cd;
    logic       lcd_cs;
    logic       fb_we;
    logic [7:0] fb_page;
    logic [7:0] fb_col;
    logic [7:0] fb_data;
    logic       disp_en;
    logic [2:0] map;
    logic [7:0] gain;
    logic       busy;
    logic       overrun;

    uc1611_rx #(
        .COL_MAX   (COL_MAX),
        .PAGE_MAX  (PAGE_MAX),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .lcd_data (lcd_data),
        .lcd_write(lcd_write),
        .lcd_cd   (lcd_cd),
        .lcd_cs   (lcd_cs),
        .fb_we    (fb_we),
        .fb_page  (fb_page),
        .fb_col   (fb_col),
        .fb_data  (fb_data),
        .disp_en  (disp_en),
        .map      (map),
        .gain     (gain),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int         m_page, m_col, m_gain, m_map, m_cnt;
    logic [2:0] m_ac, m_dc;
    bit         m_pend, m_ovr;
    bit         e_we;
    int         e_page, e_col, e_data;

    task automatic m_clear(input bit keep_ovr);
        m_page = 0; m_col = 0; m_ac = 3'b001; m_dc = 3'b000;
        m_map = 0; m_gain = 0; m_pend = 0; m_cnt = 0;
        e_we = 0; e_page = 0; e_col = 0; e_data = 0;
        if (!keep_ovr) m_ovr = 0;
    endtask

    task automatic m_advance();
        bit pg_edge, col_edge;
        int pg_next, pg_sat;
        if (!m_ac[2]) begin
            pg_edge = (m_page >= PAGE_MAX);
            pg_next = pg_edge ? 0 : m_page + 1;
            pg_sat  = PAGE_MAX;
        end else begin
            pg_edge = (m_page == 0) || (m_page > PAGE_MAX);
            pg_next = (m_page == 0) ? PAGE_MAX : ((m_page > PAGE_MAX) ? 0 : m_page - 1);
            pg_sat  = (m_page == 0) ? 0 : PAGE_MAX;
        end
        col_edge = (m_col >= COL_MAX);
        if (!m_ac[1]) begin
            if (col_edge) begin
                m_col  = 0;
                m_page = (pg_edge && !m_ac[0]) ? pg_sat : pg_next;
            end else begin
                m_col = m_col + 1;
            end
        end else begin
            m_page = pg_next;
            if (pg_edge) m_col = col_edge ? (m_ac[0] ? 0 : COL_MAX) : m_col + 1;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_clear(1'b0);
        end else begin
            e_we = 0;
            if (m_cnt > 0) begin
                if (lcd_write && lcd_cs) m_ovr = 1;
                m_cnt = m_cnt - 1;
            end else if (lcd_write && lcd_cs) begin
                if (lcd_cd) begin
                    e_we = 1; e_page = m_page; e_col = m_col; e_data = int'(lcd_data);
                    m_pend = 0;
                    m_advance();
                end else if (m_pend) begin
                    m_gain = int'(lcd_data);
                    m_pend = 0;
                end else begin
                    int d;
                    d = int'(lcd_data);
                    if (d < 16)                    m_col  = (m_col & 'hF0) | d;
                    else if (d < 32)               m_col  = (m_col & 'h0F) | ((d % 16) * 16);
                    else if (d >= 'h60 && d < 'h70) m_page = (m_page & 'hF0) | (d % 16);
                    else if (d >= 'h70 && d < 'h78) m_page = (m_page & 'h0F) | ((d % 8) * 16);
                    else if (d >= 'h88 && d < 'h90) m_ac   = 3'(d % 8);
                    else if (d >= 'hA8 && d < 'hB0) m_dc   = 3'(d % 8);
                    else if (d >= 'hC0 && d < 'hC8) m_map  = d % 8;
                    else if (d == 'h81)             m_pend = 1;
                    else if (d == 'hE2) begin
                        m_clear(1'b1);
                        m_cnt = RST_CYCLES;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("cmp fb_we", int'(fb_we), int'(e_we));
        if (e_we) begin
            check("cmp fb_page", int'(fb_page), e_page);
            check("cmp fb_col", int'(fb_col), e_col);
            check("cmp fb_data", int'(fb_data), e_data);
        end
        check("cmp busy", int'(busy), (m_cnt > 0) ? 1 : 0);
        check("cmp overrun", int'(overrun), int'(m_ovr));
        check("cmp disp_en", int'(disp_en), (m_dc == 3'b111) ? 1 : 0);
        check("cmp map", int'(map), m_map);
        check("cmp gain", int'(gain), m_gain);
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input logic cd, input logic [7:0] d, input logic cs);
        lcd_cd = cd; lcd_data = d; lcd_cs = cs; lcd_write = 1'b1;
        tick();
        lcd_write = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] d);
        send(1'b0, d, 1'b1);
    endtask

    task automatic data_chk(input logic [7:0] d, input int p, input int c);
        send(1'b1, d, 1'b1);
        check("lit we", int'(fb_we), 1);
        check("lit page", int'(fb_page), p);
        check("lit col", int'(fb_col), c);
        check("lit data", int'(fb_data), int'(d));
    endtask

    function automatic logic [7:0] pick_cmd();
        logic [3:0] lo4;
        logic [2:0] lo3;
        logic [7:0] b;
        lo4 = 4'($urandom);
        lo3 = 3'($urandom);
        case ($urandom_range(0, 9))
            0: b = {4'h0, lo4};
            1: b = {4'h1, lo4};
            2: b = {4'h6, lo4};
            3: b = {5'b01110, lo3};
            4: b = {5'b10001, lo3};
            5: b = {5'b10101, lo3};
            6: b = {5'b11000, lo3};
            7: b = 8'h81;
            8: begin
                b = 8'($urandom);
                if (b == 8'hE2) b = 8'hE3;
            end
            default: b = ($urandom_range(0, 15) == 0) ? 8'hE2 : 8'h81;
        endcase
        return b;
    endfunction

    initial begin
        int n;
        reset = 1'b1; lcd_data = 8'h00; lcd_write = 1'b0; lcd_cd = 1'b0; lcd_cs = 1'b0;
        #1 reset = 1'b0;
        tick();
        tick();
        check("rst fb_we", int'(fb_we), 0);
        check("rst busy", int'(busy), 0);
        check("rst overrun", int'(overrun), 0);
        check("rst map", int'(map), 0);
        check("rst gain", int'(gain), 0);
        check("rst disp_en", int'(disp_en), 0);
        check("rst fb_page", int'(fb_page), 0);
        check("rst fb_col", int'(fb_col), 0);
        check("rst fb_data", int'(fb_data), 0);
        reset = 1'b1;
        tick();

        // System reset: busy exactly 16 clocks
        cmd(8'hE2);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check("busy length", n, 16);

        cmd(8'h8B); cmd(8'h60); cmd(8'h70); cmd(8'h00); cmd(8'h10);
        data_chk(8'h5A, 0, 0);
        data_chk(8'hF0, 1, 0);
        data_chk(8'h0F, 2, 0);

        // Reach page 143 through a decrementing wrap, then page-primary wrap
        cmd(8'h8D); cmd(8'h60); cmd(8'h70); cmd(8'h0F); cmd(8'h19);
        data_chk(8'h11, 0, 159);
        cmd(8'h05); cmd(8'h10); cmd(8'h8B);
        data_chk(8'h22, 143, 5);
        data_chk(8'h23, 0, 6);

        // Same with column saturating (AC=8A)
        cmd(8'h8D); cmd(8'h60); cmd(8'h70); cmd(8'h0F); cmd(8'h19);
        data_chk(8'h12, 0, 159);
        cmd(8'h0F); cmd(8'h19); cmd(8'h8A);
        data_chk(8'h24, 143, 159);
        data_chk(8'h25, 0, 159);

        // Column primary with wrap into next page
        cmd(8'h89); cmd(8'h0F); cmd(8'h19); cmd(8'h63); cmd(8'h70);
        data_chk(8'hA1, 3, 159);
        data_chk(8'hA2, 4, 0);

        // Gain operand, and an operand abandoned by a data byte
        cmd(8'h81); cmd(8'h46);
        check("lit gain", int'(gain), 'h46);
        cmd(8'h81);
        data_chk(8'h33, 4, 1);
        check("lit gain kept", int'(gain), 'h46);

        // Overrun during BUSY, then asynchronous reset mid-wait
        cmd(8'hE2);
        tick(); tick(); tick();
        send(1'b1, 8'h55, 1'b1);
        check("lit busy drop we", int'(fb_we), 0);
        check("lit overrun", int'(overrun), 1);
        check("lit busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check("lit async busy", int'(busy), 0);
        check("lit async overrun", int'(overrun), 0);
        tick();
        reset = 1'b1;
        tick();

        // Chip select gating
        send(1'b0, 8'hC6, 1'b0);
        send(1'b1, 8'h77, 1'b0);
        check("lit cs map", int'(map), 0);
        check("lit cs we", int'(fb_we), 0);
        cmd(8'hC6);
        check("lit map", int'(map), 6);
        cmd(8'hAF);
        check("lit disp_en", int'(disp_en), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            lcd_write = ($urandom_range(0, 99) < 70);
            lcd_cs    = ($urandom_range(0, 7) != 0);
            lcd_cd    = 1'($urandom_range(0, 1));
            lcd_data  = lcd_cd ? 8'($urandom) : pick_cmd();
            tick();
        end
        lcd_write = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
